rns_reverse_converter_pipe: RTL and testbench
=============================================

Name: rns_reverse_converter_pipe

Overview:
- Pipelined, parametrised reverse converter for the RNS moduli set {2^N+1, 2^N, 2^N-1}, where N is the moduli parameter.
- Converts a residue triple to its binary integer X in [0, M), with M = 2^N·(2^{2N}-1).
- Generalises the fixed N=7 combinational converter with a 3-stage registered pipeline, valid/ready flow control, an invalid-residue flag and per-transaction signed (centred-range) output.
- Sits at the output of the RNS datapath, feeding binary consumers.

Parameters:
- N, 7, moduli exponent; legal range 3..16; moduli are 2^N+1, 2^N, 2^N-1.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input triple valid
- in_ready  output  1  converter can accept the input this cycle
- in_x1  input  N+1  residue mod 2^N+1
- in_x2  input  N  residue mod 2^N
- in_x3  input  N  residue mod 2^N-1; value 2^N-1 is accepted as 0
- in_signed  input  1  1 = return X in centred signed range
- out_valid  output  1  output valid
- out_ready  input  1  downstream accepts output
- out_data  output  3N  converted value; unsigned, or two's complement when in_signed was set
- out_err  output  1  input triple was invalid; qualified by out_valid

Behaviour:
- Reset: synchronous and active-high. rst=1 at a clock edge clears all stage valid bits, out_valid, out_data and out_err to 0. In-flight data is discarded, including mid-stall; no output is produced for it. in_ready may be high in the cycle rst is deasserted.
- Handshake:
  - Global advance enable: adv = !out_valid || out_ready.
  - in_ready = adv (combinational; no dependence on in_valid).
  - An input transfers when in_valid && in_ready. An output transfers when out_valid && out_ready.
  - While out_valid && !out_ready, all stages hold: out_data and out_err are stable and nothing is lost.
  - Bubbles travel with a per-stage valid bit.
- Latency and throughput:
  - Accepted input appears on out_valid exactly 3 cycles later with out_ready held high.
  - Throughput is 1 result/cycle.
  - Results leave in acceptance order.
- Stage 1:
  - Range check: err = (in_x1 > 2^N).
  - Form the 2N-bit coefficients for x1, x2 and x3 (the CRT terms mod 2^{2N}-1).
  - Compute T1 = (A1 − x1) mod (2^{2N}-1) and T2 = (A2 + A3) mod (2^{2N}-1). All adds use end-around carry.
  - Register T1, T2, x2, in_signed, err and valid.
- Stage 2:
  - Y = (T1 + T2) mod (2^{2N}-1) using an end-around-carry adder.
  - Normalise: if Y is all ones, Y = 0, so the representation is canonical.
  - Register Y with the pass-through fields.
- Stage 3:
  - X = {Y, x2} (3N bits). Result requirement: X mod (2^N+1) = x1, X mod 2^N = x2, X mod (2^N-1) = x3.
  - If in_signed && X ≥ M/2, out_data = X − M in 3N-bit two's complement; otherwise out_data = X.
  - If err, out_data = 0 and out_err = 1; otherwise out_err = 0.
- Boundaries:
  - x1 = 2^N is valid.
  - x3 = 2^N-1 is equivalent to 0.
  - Simultaneous output transfer and input accept in the same cycle is legal and required for full throughput.
  - No combinational path from in_valid to out_valid.

Test Plan (N=7, M=2097024):
- Basic conversion: (x1,x2,x3)=(97,104,111), in_signed=0, out_ready=1 → 3 cycles later out_data=1000, out_err=0.
- Extremes:
  - (128,127,126) unsigned → 2097023.
  - Same triple with in_signed=1 → 0x1FFFFF (−1).
  - (0,64,0) signed → −1048512 (0x100040); unsigned → 1048512.
  - (0,0,0) → 0.
  - (0,0,127) → 0.
- Invalid residue: x1=200 → out_err=1, out_data=0. A valid triple in the next cycle → out_err=0 with the correct value.
- Back-to-back streaming: 50 consecutive random valid triples with in_valid=1 and out_ready=1 → one result per cycle, in order. Each result matches a golden CRT model.
- Backpressure: stream with out_ready toggled randomly, including 5 consecutive low cycles →
  - in_ready follows !out_valid || out_ready;
  - out_data is stable while stalled;
  - no loss or duplication; count in equals count out.
- Reset mid-operation: assert rst for 1 cycle with 3 transactions in flight and a stall active →
  - next cycle out_valid=0, out_data=0, out_err=0;
  - none of the 3 results ever appear;
  - a new input afterwards returns correctly after 3 cycles.

Source files
------------

// File: rtl/rns_reverse_converter_pipe.sv
// Three-stage reverse converter for the RNS moduli set {2^N+1, 2^N, 2^N-1}.
// X = {Y, x2}, with Y built modulo 2^(2N)-1 using end-around-carry adders.
module rns_reverse_converter_pipe #(
    parameter int N = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N:0]     in_x1,
    input  logic [N-1:0]   in_x2,
    input  logic [N-1:0]   in_x3,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [3*N-1:0] out_data,
    output logic           out_err
);
    localparam int W = 2 * N;
    localparam logic [3*N-1:0] M_C      = {{W{1'b1}}, {N{1'b0}}};
    localparam logic [3*N-1:0] HALF_C   = {1'b0, {W{1'b1}}, {(N-1){1'b0}}};
    localparam logic [N:0]     X1_MAX_C = {1'b1, {N{1'b0}}};

    // Addition modulo 2^W-1; all-ones is the redundant encoding of zero
    function automatic logic [W-1:0] eac_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    endfunction

    logic           adv_s;
    logic [W-1:0]   a1_s, b1_s, a2_s, a3_s, y_sum_s;
    logic [3*N-1:0] x_s;

    logic           v1_q, v1_d, sg1_q, sg1_d, err1_q, err1_d;
    logic [W-1:0]   t1_q, t1_d, t2_q, t2_d;
    logic [N-1:0]   x2a_q, x2a_d;
    logic           v2_q, v2_d, sg2_q, sg2_d, err2_q, err2_d;
    logic [W-1:0]   y_q, y_d;
    logic [N-1:0]   x2b_q, x2b_d;
    logic           out_valid_q, out_valid_d, out_err_q, out_err_d;
    logic [3*N-1:0] out_data_q, out_data_d;

    // Next-state for all three stages, gated by the global advance enable
    always_comb begin
        adv_s = !out_valid_q || out_ready;
        // CRT terms as rotations: x1*2^(N-1), x1*2^(2N-1), -x2*2^N, x3*(2^(2N-1)+2^(N-1))
        a1_s = {in_x1, {(N-1){1'b0}}};
        b1_s = {in_x1[0], {(N-1){1'b0}}, in_x1[N:1]};
        a2_s = {~in_x2, {N{1'b1}}};
        a3_s = {in_x3[0], in_x3, in_x3[N-1:1]};
        y_sum_s = eac_add(t1_q, t2_q);
        x_s = {y_q, x2b_q};
        if (adv_s) begin
            v1_d   = in_valid;
            t1_d   = eac_add(a1_s, ~b1_s);
            t2_d   = eac_add(a2_s, a3_s);
            x2a_d  = in_x2;
            sg1_d  = in_signed;
            err1_d = in_x1 > X1_MAX_C;
            v2_d   = v1_q;
            y_d    = (&y_sum_s) ? {W{1'b0}} : y_sum_s;
            x2b_d  = x2a_q;
            sg2_d  = sg1_q;
            err2_d = err1_q;
            out_valid_d = v2_q;
            out_err_d   = v2_q && err2_q;
            if (!v2_q || err2_q) begin
                out_data_d = {(3*N){1'b0}};
            end else if (sg2_q && (x_s >= HALF_C)) begin
                out_data_d = x_s - M_C;
            end else begin
                out_data_d = x_s;
            end
        end else begin
            v1_d   = v1_q;
            t1_d   = t1_q;
            t2_d   = t2_q;
            x2a_d  = x2a_q;
            sg1_d  = sg1_q;
            err1_d = err1_q;
            v2_d   = v2_q;
            y_d    = y_q;
            x2b_d  = x2b_q;
            sg2_d  = sg2_q;
            err2_d = err2_q;
            out_valid_d = out_valid_q;
            out_err_d   = out_err_q;
            out_data_d  = out_data_q;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0; sg1_q <= 1'b0; err1_q <= 1'b0;
            t1_q <= {W{1'b0}}; t2_q <= {W{1'b0}}; x2a_q <= {N{1'b0}};
            v2_q <= 1'b0; sg2_q <= 1'b0; err2_q <= 1'b0;
            y_q <= {W{1'b0}}; x2b_q <= {N{1'b0}};
            out_valid_q <= 1'b0; out_err_q <= 1'b0; out_data_q <= {(3*N){1'b0}};
        end else begin
            v1_q <= v1_d; sg1_q <= sg1_d; err1_q <= err1_d;
            t1_q <= t1_d; t2_q <= t2_d; x2a_q <= x2a_d;
            v2_q <= v2_d; sg2_q <= sg2_d; err2_q <= err2_d;
            y_q <= y_d; x2b_q <= x2b_d;
            out_valid_q <= out_valid_d; out_err_q <= out_err_d; out_data_q <= out_data_d;
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
endmodule

// File: tb/tb_rns_reverse_converter_pipe.sv
// Self-checking bench for rns_reverse_converter_pipe (N=7): brute-force CRT model,
// scoreboard queue, per-cycle handshake/stall checks and directed literal vectors.
module tb_rns_reverse_converter_pipe;
    localparam int N = 7;
    localparam longint P2 = longint'(1) << N;
    localparam longint M1 = P2 + 1;
    localparam longint M3 = P2 - 1;
    localparam longint MM = P2 * M1 * M3;

    logic           clk, rst, in_valid, in_ready, in_signed, out_valid, out_ready, out_err;
    logic [N:0]     in_x1;
    logic [N-1:0]   in_x2, in_x3;
    logic [3*N-1:0] out_data;

    int checks = 0;
    int failures = 0;
    int in_cnt = 0;
    int out_cnt = 0;
    int rdy_mode = 0;
    logic [3*N:0] expq[$];

    rns_reverse_converter_pipe #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: search X = x2 + k*2^N satisfying the other two congruences, then centre if asked
    function automatic logic [3*N:0] model(input int x1, input int x2, input int x3, input bit sg);
        longint x;
        logic [63:0] v;
        if (x1 > P2) return {1'b1, {(3*N){1'b0}}};
        x = -1;
        for (longint k = 0; k < M1 * M3; k++) begin
            if (((x2 + k * P2) % M1 == x1) && ((x2 + k * P2) % M3 == x3 % M3)) begin
                x = x2 + k * P2;
                break;
            end
        end
        if (sg && x >= MM / 2) x = x - MM;
        v = x;
        return {1'b0, v[3*N-1:0]};
    endfunction

    // Downstream ready generator
    initial begin
        int rcnt;
        rcnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: begin
                    if (rcnt >= 3 && rcnt < 8) out_ready = 1'b0;
                    else out_ready = 1'($urandom_range(0, 1));
                    rcnt++;
                end
                2: out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard / protocol monitor, sampled mid-cycle
    initial begin
        bit prev_stall;
        logic [3*N:0] prev_out, e;
        prev_stall = 1'b0;
        prev_out = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_cnt -= expq.size();
                expq.delete();
                prev_stall = 1'b0;
            end else begin
                check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
                if (prev_stall) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_hold", 64'({out_err, out_data}), 64'(prev_out));
                end
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=0x%0h expected=none", {out_err, out_data});
                    end else begin
                        e = expq.pop_front();
                        check("out", 64'({out_err, out_data}), 64'(e));
                        out_cnt++;
                    end
                end
                if (in_valid && in_ready) begin
                    expq.push_back(model(int'(in_x1), int'(in_x2), int'(in_x3), in_signed));
                    in_cnt++;
                end
                prev_stall = out_valid && !out_ready;
                prev_out = {out_err, out_data};
            end
        end
    end

    task automatic send(input int x1, input int x2, input int x3, input bit sg);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_x1 = x1[N:0];
        in_x2 = x2[N-1:0];
        in_x3 = x3[N-1:0];
        in_signed = sg;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 60) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted expected=accepted");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rand();
        send(int'($urandom_range(0, 128)), int'($urandom_range(0, 127)),
             int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    endtask

    // One transaction into an empty pipe: exact 3-cycle latency and literal result
    task automatic single(input int x1, input int x2, input int x3, input bit sg,
                          input logic [3*N-1:0] exp_data, input bit exp_err);
        send(x1, x2, x3, sg);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_c2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_c3", 64'(out_valid), 64'd1);
        check("single_data", 64'(out_data), 64'(exp_data));
        check("single_err", 64'(out_err), 64'(exp_err));
        @(posedge clk);
        #1;
    endtask

    task automatic expect_next(input string name, input logic [3*N-1:0] exp_data, input bit exp_err);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_ready) && n < 20);
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_data"}, 64'(out_data), 64'(exp_data));
        check({name, "_err"}, 64'(out_err), 64'(exp_err));
    endtask

    initial begin
        time t0, t1;
        int c0, n;
        rst = 1'b1;
        in_valid = 1'b0;
        in_x1 = '0;
        in_x2 = '0;
        in_x3 = '0;
        in_signed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_err", 64'(out_err), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        check("model_1000", 64'(model(97, 104, 111, 1'b0)), 64'd1000);
        check("model_max_s", 64'(model(128, 127, 126, 1'b1)), 64'h1FFFFF);
        check("model_half_s", 64'(model(0, 64, 0, 1'b1)), 64'h100040);
        check("model_err", 64'(model(200, 0, 0, 1'b0)), 64'h200000);

        single(97, 104, 111, 1'b0, 21'd1000, 1'b0);
        single(128, 127, 126, 1'b0, 21'd2097023, 1'b0);
        single(128, 127, 126, 1'b1, 21'h1FFFFF, 1'b0);
        single(0, 64, 0, 1'b1, 21'h100040, 1'b0);
        single(0, 64, 0, 1'b0, 21'd1048512, 1'b0);
        single(0, 0, 0, 1'b0, 21'd0, 1'b0);
        single(0, 0, 127, 1'b0, 21'd0, 1'b0);

        send(200, 5, 6, 1'b0);
        send(97, 104, 111, 1'b0);
        in_valid = 1'b0;
        expect_next("invalid", 21'd0, 1'b1);
        expect_next("after_invalid", 21'd1000, 1'b0);
        idle(2);

        c0 = out_cnt;
        t0 = $time;
        for (int i = 0; i < 50; i++) send_rand();
        t1 = $time;
        idle(4);
        check("stream_cycles", 64'(t1 - t0), 64'd500);
        check("stream_count", 64'(out_cnt - c0), 64'd50);
        check("stream_empty", 64'(expq.size()), 64'd0);

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) send_rand();
        in_valid = 1'b0;
        rdy_mode = 0;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        check("bp_drain", 64'(expq.size()), 64'd0);
        check("bp_count", 64'(out_cnt), 64'(in_cnt));

        rdy_mode = 2;
        idle(2);
        send(97, 104, 111, 1'b0);
        send(1, 2, 3, 1'b1);
        send(128, 0, 127, 1'b0);
        idle(3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_data", 64'(out_data), 64'd0);
        check("midrst_err", 64'(out_err), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        idle(6);
        single(97, 104, 111, 1'b0, 21'd1000, 1'b0);
        idle(2);
        check("final_count", 64'(out_cnt), 64'(in_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
